// File: rtl/alu_if.sv
// Operand/result channel between an operand source, the ALU and a result sink.
// The master drives operands and out_ready; the slave (ALU) drives results and status.
interface alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] F;
  logic [WIDTH-1:0] F_hi;
  logic             z;
  logic             c;
  logic             o;
  logic             G;
  logic             L;
  logic             E;
  logic             busy;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, F, F_hi, z, c, o, G, L, E, busy
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, F, F_hi, z, c, o, G, L, E, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Parametrised sequential ALU: add/sub, logic, variable shift, compare flags and an
// iterative shift-add multiplier, with every result registered behind valid/ready.
module alu_pipe #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus,
  output logic dbg_state_o
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;

  logic [WIDTH-1:0]     f_q, f_d, f_hi_q, f_hi_d;
  logic                 z_q, z_d, c_q, c_d, o_q, o_d;
  logic                 g_q, g_d, l_q, l_d, e_q, e_d;
  logic                 out_valid_q, out_valid_d;

  // Handshake: a transfer happens on a posedge where valid && ready are both high.
  // The operand side is accepted only when idle and the result slot is free or
  // being drained on the same edge; out_valid holds until out_ready is seen.
  logic in_ready;
  logic accept;
  logic is_mul_op;

  assign in_ready  = rst && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign is_mul_op = (bus.op[1:0] == 2'b11) && MUL_EN;

  // Arithmetic: subtract is A + ~B + 1, decrement is A + all-ones.
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;

  always_comb begin
    add_b   = bus.B;
    add_cin = 1'b0;
    case (bus.op[3:2])
      2'b00: begin
        add_b   = bus.B;
        add_cin = 1'b0;
      end
      2'b01: begin
        add_b   = ~bus.B;
        add_cin = 1'b1;
      end
      2'b10: begin
        add_b   = '0;
        add_cin = 1'b1;
      end
      default: begin
        add_b   = '1;
        add_cin = 1'b0;
      end
    endcase
  end

  assign add_sum = {1'b0, bus.A} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  // Shifts carry one guard bit so the last bit shifted out lands in a fixed position.
  logic [SHW-1:0]          sh_n;
  logic [WIDTH:0]          sll_x;
  logic [WIDTH:0]          srl_x;
  logic signed [WIDTH:0]   sra_x;
  logic [SHW:0]            rol_r;
  logic [WIDTH-1:0]        rol_f;

  assign sh_n  = bus.B[SHW-1:0];
  assign sll_x = {1'b0, bus.A} << sh_n;
  assign srl_x = {bus.A, 1'b0} >> sh_n;
  assign sra_x = $signed({bus.A, 1'b0}) >>> sh_n;
  assign rol_r = (SHW+1)'(WIDTH) - {1'b0, sh_n};
  assign rol_f = (bus.A << sh_n) | (bus.A >> rol_r);

  logic [WIDTH-1:0] alu_f;
  logic             alu_c;
  logic             alu_o;

  always_comb begin
    alu_f = '0;
    alu_c = 1'b0;
    alu_o = 1'b0;
    case (bus.op[1:0])
      2'b00: begin
        alu_f = add_sum[WIDTH-1:0];
        alu_c = add_sum[WIDTH];
        alu_o = (bus.A[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != bus.A[WIDTH-1]);
      end
      2'b01: begin
        case (bus.op[3:2])
          2'b00:   alu_f = bus.A & bus.B;
          2'b01:   alu_f = bus.A | bus.B;
          2'b10:   alu_f = bus.A ^ bus.B;
          default: alu_f = ~bus.A;
        endcase
      end
      2'b10: begin
        case (bus.op[3:2])
          2'b00: begin
            alu_f = sll_x[WIDTH-1:0];
            alu_c = sll_x[WIDTH];
          end
          2'b01: begin
            alu_f = srl_x[WIDTH:1];
            alu_c = srl_x[0];
          end
          2'b10: begin
            alu_f = sra_x[WIDTH:1];
            alu_c = sra_x[0];
          end
          default: begin
            alu_f = rol_f;
            alu_c = 1'b0;
          end
        endcase
      end
      default: begin
        alu_f = '0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    a_d         = a_q;
    b_d         = b_q;
    f_d         = f_q;
    f_hi_d      = f_hi_q;
    z_d         = z_q;
    c_d         = c_q;
    o_d         = o_q;
    g_d         = g_q;
    l_d         = l_q;
    e_d         = e_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul_op) begin
            state_d  = S_MUL;
            cnt_d    = SHW'(WIDTH - 1);
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.A};
            mplier_d = bus.B;
            a_d      = bus.A;
            b_d      = bus.B;
          end else begin
            f_d         = alu_f;
            f_hi_d      = '0;
            z_d         = (alu_f == '0);
            c_d         = alu_c;
            o_d         = alu_o;
            g_d         = bus.A > bus.B;
            l_d         = bus.A < bus.B;
            e_d         = bus.A == bus.B;
            out_valid_d = 1'b1;
          end
        end
      end
      default: begin
        // One multiplier bit per cycle; the final partial product is folded in
        // on the same edge that publishes the result.
        prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d          = S_IDLE;
          {f_hi_d, f_d}    = prod_d;
          z_d              = (prod_d == '0);
          c_d              = (prod_d[2*WIDTH-1:WIDTH] != '0);
          o_d              = 1'b0;
          g_d              = a_q > b_q;
          l_d              = a_q < b_q;
          e_d              = a_q == b_q;
          out_valid_d      = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      f_q         <= '0;
      f_hi_q      <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      o_q         <= 1'b0;
      g_q         <= 1'b0;
      l_q         <= 1'b0;
      e_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      a_q         <= a_d;
      b_q         <= b_d;
      f_q         <= f_d;
      f_hi_q      <= f_hi_d;
      z_q         <= z_d;
      c_q         <= c_d;
      o_q         <= o_d;
      g_q         <= g_d;
      l_q         <= l_d;
      e_q         <= e_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.F         = f_q;
  assign bus.F_hi      = f_hi_q;
  assign bus.z         = z_q;
  assign bus.c         = c_q;
  assign bus.o         = o_q;
  assign bus.G         = g_q;
  assign bus.L         = l_q;
  assign bus.E         = e_q;
  assign bus.busy      = (state_q == S_MUL);
  assign dbg_state_o   = (state_q == S_MUL);

endmodule
